ball_engine: RTL and testbench

- Parametrised successor to the single-square bouncing-ball generator for the Breakout VGA path.
- Owns ball position, per-axis direction and speed, and a SERVE/MOVE/LOST play state.
- Handles wall, paddle and brick reflections independently per axis, clamped at the boundaries.
- Produces the per-pixel ball-on signal for the colour mux and a ball-lost event for the score/lives logic.

---
 rtl/ball_pkg.sv | 23 ++
 rtl/ball_axis.sv | 59 +++++
 rtl/ball_engine.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ball_engine.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared definitions for the Breakout ball engine.
//
// Contents:
//   StServe/StMove/StLost : play-state encodings, also driven out on playState
//   DIR_POS/DIR_NEG       : per-axis direction encodings (positive = right/down)
//   SGN_GUARD, sgn_width  : guard bits for signed position arithmetic (POS_W + 2)
package ball_pkg;

  localparam logic [1:0] StServe = 2'd0;
  localparam logic [1:0] StMove  = 2'd1;
  localparam logic [1:0] StLost  = 2'd2;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  // One bit for sign, one for headroom above 2^POS_W.
  localparam int unsigned SGN_GUARD = 2;

  function automatic int unsigned sgn_width(input int unsigned pos_w);
    return pos_w + SGN_GUARD;
  endfunction

endpackage

// File: rtl/ball_axis.sv
// One-axis ball step with wall clamp and reflection.
//
// Ports:
//   pos      in  current ball coordinate (left column or top row)
//   dir      in  direction, already including any pending brick flip
//   speed    in  pixels per frame
//   lo, hi   in  legal coordinate range of the ball's leading corner
//   nextPos  out stepped coordinate clamped into [lo, hi]
//   nextDir  out direction after reflection
//   nextRaw  out unclamped signed step result (POS_W + 2 bits)
//   hitLo    out step landed at or below lo
//   hitHi    out step landed at or above hi
module ball_axis
  import ball_pkg::*;
#(
  parameter int unsigned POS_W = 10,
  parameter int unsigned SPD_W = 3
) (
  input  logic                                  [POS_W-1:0] pos,
  input  logic                                              dir,
  input  logic                                  [SPD_W-1:0] speed,
  input  logic                                  [POS_W-1:0] lo,
  input  logic                                  [POS_W-1:0] hi,
  output logic                                  [POS_W-1:0] nextPos,
  output logic                                              nextDir,
  output logic signed [sgn_width(POS_W)-1:0]                nextRaw,
  output logic                                              hitLo,
  output logic                                              hitHi
);

  localparam int unsigned SW = sgn_width(POS_W);

  logic signed [SW-1:0] pos_s, spd_s, lo_s, hi_s, step_s;

  assign pos_s = $signed({2'b00, pos});
  assign spd_s = $signed({{(SW - SPD_W){1'b0}}, speed});
  assign lo_s  = $signed({2'b00, lo});
  assign hi_s  = $signed({2'b00, hi});

  assign step_s = (dir == DIR_NEG) ? (pos_s - spd_s) : (pos_s + spd_s);

  assign hitLo   = (step_s <= lo_s);
  assign hitHi   = (step_s >= hi_s);
  assign nextRaw = step_s;

  // Low wall wins if a degenerate range makes both true.
  always_comb begin
    nextPos = step_s[POS_W-1:0];
    nextDir = dir;
    if (hitLo) begin
      nextPos = lo;
      nextDir = DIR_POS;
    end else if (hitHi) begin
      nextPos = hi;
      nextDir = DIR_NEG;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Breakout ball engine: position, direction, speed and SERVE/MOVE/LOST play state.
// State advances once per frame on the cycle where (pixelY == TICK_LINE && pixelX == 0).
//
// Optional build macro: BALL_ENGINE_SPEED_RAMP_EN adds a paddle-hit counter that raises
// speed by one every RAMP_HITS paddle hits up to SPEED_MAX. Without it speed is SPEED_INIT.
//
// Ports:
//   clock, reset        pixel clock, asynchronous active-low reset
//   pixelX, pixelY      current scan position
//   paddleX             paddle left column
//   launch              serve request, sampled on a tick while in SERVE
//   brickHit/Side       brick collision pulse; side 0 flips Y, side 1 flips X
//   ballOn              current pixel lies inside the ball (combinational)
//   ballX, ballY        ball top-left corner
//   lostPulse           one-cycle pulse on entry to LOST
//   playState           0 = SERVE, 1 = MOVE, 2 = LOST
module ball_engine
  import ball_pkg::*;
#(
  parameter int unsigned POS_W        = 10,
  parameter int unsigned BALL_SIZE    = 10,
  parameter int unsigned FIELD_LEFT   = 32,
  parameter int unsigned FIELD_RIGHT  = 630,
  parameter int unsigned FIELD_TOP    = 22,
  parameter int unsigned FIELD_BOTTOM = 470,
  parameter int unsigned PADDLE_Y     = 450,
  parameter int unsigned PADDLE_W     = 64,
  parameter int unsigned SPEED_INIT   = 2,
  parameter int unsigned SPEED_MAX    = 6,
  parameter int unsigned RAMP_HITS    = 4,
  parameter int unsigned LOST_FRAMES  = 60,
  parameter int unsigned TICK_LINE    = 481
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [POS_W-1:0] pixelX,
  input  logic [POS_W-1:0] pixelY,
  input  logic [POS_W-1:0] paddleX,
  input  logic             launch,
  input  logic             brickHit,
  input  logic             brickHitSide,
  output logic             ballOn,
  output logic [POS_W-1:0] ballX,
  output logic [POS_W-1:0] ballY,
  output logic             lostPulse,
  output logic [1:0]       playState
);

  localparam int unsigned SW    = sgn_width(POS_W);
  localparam int unsigned SpdW  = $clog2(SPEED_MAX + 1);
  localparam int unsigned LostW = $clog2(LOST_FRAMES + 1);

  localparam logic [POS_W-1:0] XLo    = POS_W'(FIELD_LEFT);
  localparam logic [POS_W-1:0] XHi    = POS_W'(FIELD_RIGHT - BALL_SIZE + 1);
  localparam logic [POS_W-1:0] YLo    = POS_W'(FIELD_TOP);
  localparam logic [POS_W-1:0] YHi    = POS_W'(FIELD_BOTTOM - BALL_SIZE + 1);
  localparam logic [POS_W-1:0] ServeY = POS_W'(PADDLE_Y - BALL_SIZE);
  localparam logic [POS_W:0]   BallEnd = (POS_W + 1)'(BALL_SIZE - 1);

  localparam logic [SpdW-1:0]  SpdInit  = SpdW'(SPEED_INIT);
  localparam logic [LostW-1:0] LostLast = LostW'(LOST_FRAMES - 1);

  localparam logic signed [SW-1:0] BallM1   = SW'(BALL_SIZE - 1);
  localparam logic signed [SW-1:0] PadYS    = SW'(PADDLE_Y);
  localparam logic signed [SW-1:0] PadM1    = SW'(PADDLE_W - 1);
  localparam logic signed [SW-1:0] ServeOff = SW'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic signed [SW-1:0] XLoS     = SW'(FIELD_LEFT);
  localparam logic signed [SW-1:0] XHiS     = SW'(FIELD_RIGHT - BALL_SIZE + 1);

  logic [1:0]       state_q, state_d;
  logic [POS_W-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic             flip_x_q, flip_x_d, flip_y_q, flip_y_d;
  logic [LostW-1:0] lost_cnt_q, lost_cnt_d;
  logic             lost_pulse_q, lost_pulse_d;
  logic [SpdW-1:0]  speed;

  logic frame_tick;
  assign frame_tick = (pixelY == POS_W'(TICK_LINE)) && (pixelX == '0);

  // Pending brick flips take effect before this tick's step.
  logic eff_dir_x, eff_dir_y;
  assign eff_dir_x = dir_x_q ^ flip_x_q;
  assign eff_dir_y = dir_y_q ^ flip_y_q;

  logic [POS_W-1:0]    x_next, y_next;
  logic                x_dir_next, y_dir_next;
  logic signed [SW-1:0] x_raw, y_raw;
  logic                x_hit_lo, x_hit_hi, y_hit_lo, y_hit_hi;

  ball_axis #(
    .POS_W (POS_W),
    .SPD_W (SpdW)
  ) u_axis_x (
    .pos     (ball_x_q),
    .dir     (eff_dir_x),
    .speed   (speed),
    .lo      (XLo),
    .hi      (XHi),
    .nextPos (x_next),
    .nextDir (x_dir_next),
    .nextRaw (x_raw),
    .hitLo   (x_hit_lo),
    .hitHi   (x_hit_hi)
  );

  // Y high bound is the lost line, not a reflecting wall.
  ball_axis #(
    .POS_W (POS_W),
    .SPD_W (SpdW)
  ) u_axis_y (
    .pos     (ball_y_q),
    .dir     (eff_dir_y),
    .speed   (speed),
    .lo      (YLo),
    .hi      (YHi),
    .nextPos (y_next),
    .nextDir (y_dir_next),
    .nextRaw (y_raw),
    .hitLo   (y_hit_lo),
    .hitHi   (y_hit_hi)
  );

  logic unused_x;
  assign unused_x = ^{x_raw, x_hit_lo, x_hit_hi};

  logic signed [SW-1:0] bx_s, by_s, pad_s, srv_s;
  assign bx_s  = $signed({2'b00, ball_x_q});
  assign by_s  = $signed({2'b00, ball_y_q});
  assign pad_s = $signed({2'b00, paddleX});
  assign srv_s = pad_s + ServeOff;

  // Descending onto the paddle from strictly above it with overlapping columns.
  logic paddle_hit;
  assign paddle_hit = (eff_dir_y == DIR_POS) &&
                      (y_raw + BallM1 >= PadYS) &&
                      (by_s + BallM1 < PadYS) &&
                      (bx_s <= pad_s + PadM1) &&
                      (bx_s + BallM1 >= pad_s);

  logic [POS_W-1:0] serve_x;
  assign serve_x = (srv_s < XLoS) ? XLo :
                   (srv_s > XHiS) ? XHi : srv_s[POS_W-1:0];

`ifdef BALL_ENGINE_SPEED_RAMP_EN
  localparam int unsigned      HitW    = $clog2(RAMP_HITS + 1);
  localparam logic [HitW-1:0]  HitLast = HitW'(RAMP_HITS - 1);
  localparam logic [SpdW-1:0]  SpdMax  = SpdW'(SPEED_MAX);

  logic [SpdW-1:0] speed_q, speed_d;
  logic [HitW-1:0] hit_cnt_q, hit_cnt_d;

  assign speed = speed_q;

  always_comb begin
    speed_d   = speed_q;
    hit_cnt_d = hit_cnt_q;
    if (frame_tick) begin
      unique case (state_q)
        StServe: if (launch) speed_d = SpdInit;
        StMove: begin
          if (!y_hit_lo && paddle_hit) begin
            if (hit_cnt_q == HitLast) begin
              hit_cnt_d = '0;
              if (speed_q < SpdMax) speed_d = speed_q + 1'b1;
            end else begin
              hit_cnt_d = hit_cnt_q + 1'b1;
            end
          end
        end
        StLost: begin
          if (lost_cnt_q == LostLast) begin
            speed_d   = SpdInit;
            hit_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      speed_q   <= SpdInit;
      hit_cnt_q <= '0;
    end else begin
      speed_q   <= speed_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end
`else
  assign speed = SpdInit;

  logic unused_ramp;
  assign unused_ramp = ^RAMP_HITS;
`endif

  always_comb begin
    state_d      = state_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    lost_cnt_d   = lost_cnt_q;
    lost_pulse_d = 1'b0;

    // Latches clear on a tick but a hit arriving in the tick cycle survives it.
    flip_x_d = frame_tick ? 1'b0 : flip_x_q;
    flip_y_d = frame_tick ? 1'b0 : flip_y_q;
    if (brickHit && (state_q == StMove)) begin
      if (brickHitSide) flip_x_d = 1'b1;
      else              flip_y_d = 1'b1;
    end

    if (frame_tick) begin
      unique case (state_q)
        StServe: begin
          ball_x_d = serve_x;
          ball_y_d = ServeY;
          if (launch) begin
            state_d = StMove;
            dir_x_d = DIR_POS;
            dir_y_d = DIR_NEG;
          end
        end
        StMove: begin
          ball_x_d = x_next;
          dir_x_d  = x_dir_next;
          ball_y_d = y_next;
          dir_y_d  = y_dir_next;
          if (!y_hit_lo) begin
            if (paddle_hit) begin
              ball_y_d = ServeY;
              dir_y_d  = DIR_NEG;
            end else if (y_hit_hi) begin
              state_d      = StLost;
              lost_pulse_d = 1'b1;
              lost_cnt_d   = '0;
            end
          end
        end
        StLost: begin
          if (lost_cnt_q == LostLast) begin
            state_d    = StServe;
            lost_cnt_d = '0;
          end else begin
            lost_cnt_d = lost_cnt_q + 1'b1;
          end
        end
        default: state_d = StServe;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StServe;
      ball_x_q     <= XLo;
      ball_y_q     <= ServeY;
      dir_x_q      <= DIR_POS;
      dir_y_q      <= DIR_NEG;
      flip_x_q     <= 1'b0;
      flip_y_q     <= 1'b0;
      lost_cnt_q   <= '0;
      lost_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      flip_x_q     <= flip_x_d;
      flip_y_q     <= flip_y_d;
      lost_cnt_q   <= lost_cnt_d;
      lost_pulse_q <= lost_pulse_d;
    end
  end

  assign ballOn = (state_q != StLost) &&
                  ({1'b0, pixelX} >= {1'b0, ball_x_q}) &&
                  ({1'b0, pixelX} <= {1'b0, ball_x_q} + BallEnd) &&
                  ({1'b0, pixelY} >= {1'b0, ball_y_q}) &&
                  ({1'b0, pixelY} <= {1'b0, ball_y_q} + BallEnd);

  assign ballX     = ball_x_q;
  assign ballY     = ball_y_q;
  assign lostPulse = lost_pulse_q;
  assign playState = state_q;

endmodule

// File: tb/tb_ball_engine.sv
// Randomised scoreboard bench for ball_engine against a frame-level reference model.
module tb_ball_engine;

  localparam int BS = 10, FL = 32, FR = 630, FT = 22, FB = 470, PY = 450, PW = 64;
  localparam int SP_INIT = 2, SP_MAX = 6, RAMP = 4, LOSTF = 60, TICK = 481;
  localparam int NF = 2500;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] pixelX = 10'd5, pixelY = 10'd5, paddleX = 10'd200;
  logic       launch = 1'b0, brickHit = 1'b0, brickHitSide = 1'b0;
  logic       ballOn, lostPulse;
  logic [9:0] ballX, ballY;
  logic [1:0] playState;

  ball_engine dut (
    .clock        (clock),
    .reset        (reset),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .paddleX      (paddleX),
    .launch       (launch),
    .brickHit     (brickHit),
    .brickHitSide (brickHitSide),
    .ballOn       (ballOn),
    .ballX        (ballX),
    .ballY        (ballY),
    .lostPulse    (lostPulse),
    .playState    (playState)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st;
    int x;
    int y;
    bit lost;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: 0 = SERVE, 1 = MOVE, 2 = LOST; directions as +1 / -1.
  int m_st, m_x, m_y, m_dx, m_dy, m_spd, m_hits, m_lostc;
  bit m_fx, m_fy;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_on(input exp_t c, input int px, input int py);
    return (c.st != 2) && (px >= c.x) && (px <= c.x + BS - 1) && (py >= c.y) && (py <= c.y + BS - 1);
  endfunction

  task automatic model_reset();
    m_st = 0; m_x = FL; m_y = PY - BS; m_dx = 1; m_dy = -1;
    m_spd = SP_INIT; m_hits = 0; m_lostc = 0; m_fx = 0; m_fy = 0;
  endtask

  task automatic model_brick(input bit bh, input bit side);
    if (bh && m_st == 1) begin
      if (side) m_fx = 1;
      else      m_fy = 1;
    end
  endtask

  task automatic model_tick(input bit l, input int pad, input bit bh, input bit side,
                            output bit lost);
    bit nfx, nfy;
    int nx, ny, ox, oy;
    nfx  = bh && (m_st == 1) && side;
    nfy  = bh && (m_st == 1) && !side;
    lost = 0;
    case (m_st)
      0: begin
        m_x = pad + PW / 2 - BS / 2;
        if (m_x < FL) m_x = FL;
        if (m_x > FR - BS + 1) m_x = FR - BS + 1;
        m_y = PY - BS;
        if (l) begin
          m_st = 1; m_dx = 1; m_dy = -1; m_spd = SP_INIT;
        end
      end
      1: begin
        if (m_fx) m_dx = -m_dx;
        if (m_fy) m_dy = -m_dy;
        ox = m_x; oy = m_y;
        nx = m_x + m_dx * m_spd;
        ny = m_y + m_dy * m_spd;
        if (nx <= FL) begin
          m_x = FL; m_dx = 1;
        end else if (nx + BS - 1 >= FR) begin
          m_x = FR - BS + 1; m_dx = -1;
        end else m_x = nx;
        if (ny <= FT) begin
          m_y = FT; m_dy = 1;
        end else if (m_dy > 0 && ny + BS - 1 >= PY && oy + BS - 1 < PY &&
                     ox <= pad + PW - 1 && ox + BS - 1 >= pad) begin
          m_y = PY - BS; m_dy = -1;
`ifdef BALL_ENGINE_SPEED_RAMP_EN
          m_hits++;
          if (m_hits == RAMP) begin
            m_hits = 0;
            if (m_spd < SP_MAX) m_spd++;
          end
`endif
        end else if (ny + BS - 1 >= FB) begin
          m_st = 2; m_lostc = 0; lost = 1; m_y = FB - BS + 1;
        end else m_y = ny;
      end
      default: begin
        if (m_lostc == LOSTF - 1) begin
          m_st = 0; m_lostc = 0; m_hits = 0; m_spd = SP_INIT;
        end else m_lostc++;
      end
    endcase
    m_fx = nfx;
    m_fy = nfy;
  endtask

  function automatic int clip(input int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  // Stimulus: one tick cycle then three ordinary cycles per frame.
  initial begin
    bit lost, did_reset, l, bh, side;
    int pad, px, py;
    did_reset = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    for (int f = 0; f < NF; f++) begin
      if (f >= NF / 2 && !did_reset && m_st == 1) begin
        @(posedge clock);
        #2;
        reset = 1'b0; brickHit = 1'b0; launch = 1'b0;
        model_reset();
        did_reset = 1;
        @(posedge clock);
        #2 reset = 1'b1;
      end
      @(posedge clock);
      #2;
      if ($urandom_range(0, 9) < 8) pad = clip(m_x - int'($urandom_range(0, 70)));
      else pad = $urandom_range(0, 600);
      l    = ($urandom_range(0, 3) == 0);
      bh   = ($urandom_range(0, 3) == 0);
      side = $urandom_range(0, 1);
      pixelX = 10'd0; pixelY = 10'(TICK); paddleX = 10'(pad);
      launch = l; brickHit = bh; brickHitSide = side;
      model_tick(l, pad, bh, side, lost);
      q.push_back('{m_st, m_x, m_y, lost});
      for (int k = 0; k < 3; k++) begin
        @(posedge clock);
        #2;
        bh   = ($urandom_range(0, 4) == 0);
        side = $urandom_range(0, 1);
        px   = clip(m_x + int'($urandom_range(0, 14)) - 2);
        py   = clip(m_y + int'($urandom_range(0, 14)) - 2);
        if (px == 0 && py == TICK) py = TICK + 1;
        pixelX = 10'(px); pixelY = 10'(py);
        launch = $urandom_range(0, 1); brickHit = bh; brickHitSide = side;
        model_brick(bh, side);
      end
    end
    @(posedge clock);
    #2 brickHit = 1'b0;
    repeat (3) @(posedge clock);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Monitor: a tick edge is the DUT's output event; compare on the following negedge.
  initial begin
    exp_t cur, e;
    bit   was_tick;
    cur = '{0, FL, PY - BS, 0};
    forever begin
      @(posedge clock);
      was_tick = reset && (pixelX == 10'd0) && (pixelY == 10'(TICK));
      @(negedge clock);
      if (!reset) begin
        cur = '{0, FL, PY - BS, 0};
        check("reset_state", int'(playState), 0);
        check("reset_ballX", int'(ballX), FL);
        check("reset_ballY", int'(ballY), PY - BS);
        check("reset_lostPulse", int'(lostPulse), 0);
      end else begin
        if (was_tick) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: tick with no expected entry at %0t", $time);
          end else begin
            e = q.pop_front();
            check("tick_state", int'(playState), e.st);
            check("tick_ballX", int'(ballX), e.x);
            check("tick_ballY", int'(ballY), e.y);
            check("tick_lostPulse", int'(lostPulse), int'(e.lost));
            cur = e;
          end
        end else begin
          check("idle_lostPulse", int'(lostPulse), 0);
        end
        check("ballOn", int'(ballOn), int'(model_on(cur, int'(pixelX), int'(pixelY))));
      end
    end
  end

endmodule
